// File: rtl/prbs_symbol_generator_pkg.sv
// ---------------------------------------------------------------------------
// ofdm_gen_pkg
// Shared definitions for the PRBS symbol generator:
//   - mode_e       : source select (PRBS7, PRBS15, counter, fixed pattern)
//   - LFSR_W       : width of the shared LFSR register (15)
//   - *_TAPS       : feedback tap masks for x^7+x^6+1 and x^15+x^14+1
//   - guard_seed() : replaces an all-zero active seed with all-ones
// ---------------------------------------------------------------------------
package ofdm_gen_pkg;

  localparam int LFSR_W = 15;

  typedef enum logic [1:0] {
    MODE_PRBS7  = 2'd0,
    MODE_PRBS15 = 2'd1,
    MODE_CNT    = 2'd2,
    MODE_FIXED  = 2'd3
  } mode_e;

  // Feedback is the XOR of the tapped bits of the current state.
  localparam logic [LFSR_W-1:0] PRBS7_TAPS  = 15'h0060;  // bits 6,5
  localparam logic [LFSR_W-1:0] PRBS15_TAPS = 15'h6000;  // bits 14,13
  localparam logic [LFSR_W-1:0] PRBS7_MASK  = 15'h007F;

  // An all-zero LFSR locks up, so a zero in the active width is forced to
  // all-ones. For PRBS7 only the low 7 bits are active.
  function automatic logic [LFSR_W-1:0] guard_seed(input logic [LFSR_W-1:0] s,
                                                   input logic              wide);
    logic [LFSR_W-1:0] r;
    r = s;
    if (wide) begin
      if (s == '0) r = '1;
    end else if ((s & PRBS7_MASK) == '0) begin
      r = s | PRBS7_MASK;
    end
    return r;
  endfunction

endpackage

// File: rtl/prbs_symbol_generator_if.sv
// ---------------------------------------------------------------------------
// prbs_symbol_generator_if
// Symbol stream towards the mapper with valid/ready handshake and framing.
//   data  : SYM_W-bit symbol
//   valid : symbol valid (source)
//   ready : sink accepts (sink)
//   sof   : first symbol of frame
//   eof   : last symbol of frame
// Modports: master (generator side), slave (mapper side).
// ---------------------------------------------------------------------------
interface prbs_symbol_generator_if #(
  parameter int SYM_W = 4
);
  logic [SYM_W-1:0] data;
  logic             valid;
  logic             ready;
  logic             sof;
  logic             eof;

  modport master (output data, output valid, output sof, output eof, input ready);
  modport slave  (input data, input valid, input sof, input eof, output ready);
endinterface

// File: rtl/prbs_symbol_generator_lfsr_step.sv
// ---------------------------------------------------------------------------
// lfsr_step
// Combinational N-step advance of the shared Fibonacci, shift-left LFSR.
//   state      : current 15-bit LFSR state
//   wide       : 1 = PRBS15 (x^15+x^14+1), 0 = PRBS7 (x^7+x^6+1) on bits [6:0]
//   state_next : state after N steps
//   bits       : the N output bits, first bit in bits[N-1]
// The output bit of each step is the MSB of the active width before shifting.
// In PRBS7 mode bits [14:7] are carried through untouched.
// ---------------------------------------------------------------------------
module lfsr_step
  import ofdm_gen_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [LFSR_W-1:0] state,
  input  logic              wide,
  output logic [LFSR_W-1:0] state_next,
  output logic [N-1:0]      bits
);

  always_comb begin
    logic [LFSR_W-1:0] s;
    logic              fb;
    s    = state;
    fb   = 1'b0;
    bits = '0;
    for (int i = 0; i < N; i++) begin
      bits[N-1-i] = wide ? s[LFSR_W-1] : s[6];
      fb          = ^(s & (wide ? PRBS15_TAPS : PRBS7_TAPS));
      s           = wide ? {s[LFSR_W-2:0], fb} : {s[LFSR_W-1:7], s[5:0], fb};
    end
    state_next = s;
  end

endmodule

// File: rtl/prbs_symbol_generator.sv
// ---------------------------------------------------------------------------
// prbs_symbol_generator
// Framed SYM_W-bit symbol source for the OFDM mapper. Sources: PRBS7, PRBS15,
// incrementing counter, fixed pattern. One symbol per cycle sustained.
//   clk, reset : clock and synchronous active-high reset
//   start      : frame request, honoured in IDLE (latches mode/pattern)
//   mode       : source select
//   pattern    : fixed-mode symbol
//   seed_load  : load seed into the LFSR, honoured in IDLE
//   seed       : seed value (PRBS7 uses seed[6:0])
//   sym        : symbol stream (data/valid/ready/sof/eof), master side
//   busy       : high while a frame is in progress
// The output register always holds the symbol on offer; the LFSR register
// already holds the state after that symbol's bits, so the next symbol is
// ready combinationally when the current one transfers.
// ---------------------------------------------------------------------------
module prbs_symbol_generator
  import ofdm_gen_pkg::*;
#(
  parameter int                SYM_W     = 4,
  parameter int                FRAME_LEN = 64,
  parameter logic [LFSR_W-1:0] SEED      = 15'h7FFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [1:0]                    mode,
  input  logic [SYM_W-1:0]              pattern,
  input  logic                          seed_load,
  input  logic [LFSR_W-1:0]             seed,
  prbs_symbol_generator_if.master       sym,
  output logic                          busy
);

  localparam int              IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e            state_reg, state_next;
  logic [LFSR_W-1:0] lfsr_reg, lfsr_next;
  mode_e             mode_reg, mode_next;
  logic [SYM_W-1:0]  pattern_reg, pattern_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [SYM_W-1:0]  data_reg, data_next;
  logic              valid_reg, valid_next;
  logic              sof_reg, sof_next;
  logic              eof_reg, eof_next;

  logic              idle;
  logic              fire;
  mode_e             gen_mode;
  logic [SYM_W-1:0]  gen_pattern;
  logic [IDX_W-1:0]  gen_idx;
  logic [LFSR_W-1:0] gen_src;
  logic              gen_prbs;
  logic [LFSR_W-1:0] step_state;
  logic [SYM_W-1:0]  step_bits;
  logic [SYM_W-1:0]  gen_sym;

  assign idle = (state_reg == ST_IDLE);
  assign fire = valid_reg & sym.ready;

  // In IDLE the candidate symbol is the first of a new frame, built from the
  // live inputs that start is about to latch; in RUN it is the next symbol of
  // the current frame built from the latched settings.
  assign gen_mode    = idle ? mode_e'(mode) : mode_reg;
  assign gen_pattern = idle ? pattern : pattern_reg;
  assign gen_idx     = idle ? '0 : idx_reg + IDX_W'(1);
  assign gen_prbs    = (gen_mode == MODE_PRBS7) || (gen_mode == MODE_PRBS15);

  // A seed loaded in the same cycle as start feeds the first symbol directly.
  assign gen_src = (idle && seed_load) ? guard_seed(seed, gen_mode != MODE_PRBS7)
                                       : lfsr_reg;

  lfsr_step #(.N(SYM_W)) u_step (
    .state      (gen_src),
    .wide       (gen_mode == MODE_PRBS15),
    .state_next (step_state),
    .bits       (step_bits)
  );

  always_comb begin
    gen_sym = step_bits;
    case (gen_mode)
      MODE_CNT:   gen_sym = SYM_W'(gen_idx);
      MODE_FIXED: gen_sym = gen_pattern;
      default:    gen_sym = step_bits;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    lfsr_next    = lfsr_reg;
    mode_next    = mode_reg;
    pattern_next = pattern_reg;
    idx_next     = idx_reg;
    data_next    = data_reg;
    valid_next   = valid_reg;
    sof_next     = sof_reg;
    eof_next     = eof_reg;
    case (state_reg)
      ST_IDLE: begin
        if (seed_load) lfsr_next = gen_src;
        if (start) begin
          state_next   = ST_RUN;
          mode_next    = gen_mode;
          pattern_next = pattern;
          idx_next     = '0;
          data_next    = gen_sym;
          valid_next   = 1'b1;
          sof_next     = 1'b1;
          eof_next     = 1'b0;  // frames hold at least two symbols
          if (gen_prbs) lfsr_next = step_state;
        end
      end
      ST_RUN: begin
        if (fire) begin
          if (eof_reg) begin
            state_next = ST_IDLE;
            data_next  = '0;
            valid_next = 1'b0;
            sof_next   = 1'b0;
            eof_next   = 1'b0;
          end else begin
            idx_next  = gen_idx;
            data_next = gen_sym;
            sof_next  = 1'b0;
            eof_next  = (gen_idx == LAST_IDX);
            if (gen_prbs) lfsr_next = step_state;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      lfsr_reg    <= SEED;
      mode_reg    <= MODE_PRBS7;
      pattern_reg <= '0;
      idx_reg     <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      sof_reg     <= 1'b0;
      eof_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lfsr_reg    <= lfsr_next;
      mode_reg    <= mode_next;
      pattern_reg <= pattern_next;
      idx_reg     <= idx_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      sof_reg     <= sof_next;
      eof_reg     <= eof_next;
    end
  end

  assign sym.data  = data_reg;
  assign sym.valid = valid_reg;
  assign sym.sof   = sof_reg;
  assign sym.eof   = eof_reg;
  assign busy      = (state_reg == ST_RUN);

endmodule

// File: tb/tb_prbs_symbol_generator.sv
// ---------------------------------------------------------------------------
// tb_prbs_symbol_generator
// Directed sequence with randomized ready/backpressure and RUN-time noise on
// start/seed_load/mode/pattern, checked against a bit-level reference model
// of the PRBS polynomials, counter and fixed sources.
// ---------------------------------------------------------------------------
module tb_prbs_symbol_generator;
  import ofdm_gen_pkg::*;

  localparam int                SYM_W     = 4;
  localparam int                FRAME_LEN = 64;
  localparam logic [LFSR_W-1:0] SEED      = 15'h7FFF;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [1:0]        mode;
  logic [SYM_W-1:0]  pattern;
  logic              seed_load;
  logic [LFSR_W-1:0] seed;
  logic              busy;

  prbs_symbol_generator_if #(.SYM_W(SYM_W)) sym ();

  prbs_symbol_generator #(
    .SYM_W     (SYM_W),
    .FRAME_LEN (FRAME_LEN),
    .SEED      (SEED)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .pattern   (pattern),
    .seed_load (seed_load),
    .seed      (seed),
    .sym       (sym),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [SYM_W-1:0] d;
    logic             s;
    logic             e;
  } exp_t;

  exp_t             exp_q[$];
  logic [SYM_W-1:0] rx_q[$];
  logic [SYM_W-1:0] stream_q[$];
  bit               record_stream = 1'b0;
  int unsigned      m_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---- reference model --------------------------------------------------
  function automatic bit m_bit(input bit wide);
    int unsigned low, b, fb;
    if (wide) begin
      b    = (m_st >> 14) & 1;
      fb   = ((m_st >> 14) ^ (m_st >> 13)) & 1;
      m_st = ((m_st << 1) | fb) & 32'h7FFF;
    end else begin
      low  = m_st & 32'h7F;
      b    = (low >> 6) & 1;
      fb   = ((low >> 6) ^ (low >> 5)) & 1;
      m_st = (m_st & 32'h7F80) | (((low << 1) | fb) & 32'h7F);
    end
    return b[0];
  endfunction

  function automatic void m_seed(input int unsigned s, input int md);
    if (md == 0) m_st = ((s & 32'h7F) == 0) ? (s | 32'h7F) : s;
    else         m_st = (s == 0) ? 32'h7FFF : s;
  endfunction

  function automatic void m_frame(input int md, input int unsigned pat);
    exp_t        e;
    int unsigned v;
    for (int k = 0; k < FRAME_LEN; k++) begin
      v = 0;
      case (md)
        0: for (int b = 0; b < SYM_W; b++) v = (v << 1) | int'(m_bit(1'b0));
        1: for (int b = 0; b < SYM_W; b++) v = (v << 1) | int'(m_bit(1'b1));
        2: v = k % (1 << SYM_W);
        default: v = pat;
      endcase
      e.d = SYM_W'(v);
      e.s = (k == 0);
      e.e = (k == FRAME_LEN - 1);
      exp_q.push_back(e);
    end
  endfunction

  // ---- stimulus tasks (entered and left at a negedge) -------------------
  task automatic check_outputs_zero(input string tag);
    chk({tag, "_data"},  32'(sym.data),  32'h0);
    chk({tag, "_valid"}, 32'(sym.valid), 32'h0);
    chk({tag, "_sof"},   32'(sym.sof),   32'h0);
    chk({tag, "_eof"},   32'(sym.eof),   32'h0);
    chk({tag, "_busy"},  32'(busy),      32'h0);
  endtask

  task automatic start_frame(input int md, input int unsigned pat,
                             input bit do_seed, input int unsigned sd);
    mode      = 2'(md);
    pattern   = SYM_W'(pat);
    start     = 1'b1;
    seed_load = do_seed;
    seed      = LFSR_W'(sd);
    if (do_seed) m_seed(sd & 32'h7FFF, md);
    m_frame(md, pat);
    @(negedge clk);
    start     = 1'b0;
    seed_load = 1'b0;
    chk("start_busy",  32'(busy),      32'h1);
    chk("start_valid", 32'(sym.valid), 32'h1);
  endtask

  task automatic recv(input int pct, input bit noise, input int nsym);
    int               got  = 0;
    int               cyc  = 0;
    bit               held = 1'b0;
    bit               rdy;
    logic [SYM_W-1:0] hd;
    logic             hs, he;
    exp_t             e;
    rx_q.delete();
    while (got < nsym && cyc < 4000) begin
      chk("valid_in_frame", 32'(sym.valid), 32'h1);
      if (held) begin
        chk("stall_data", 32'(sym.data), 32'(hd));
        chk("stall_sof",  32'(sym.sof),  32'(hs));
        chk("stall_eof",  32'(sym.eof),  32'(he));
      end
      rdy       = ($urandom_range(99) < pct);
      sym.ready = rdy;
      if (noise) begin
        start     = 1'($urandom_range(1));
        seed_load = 1'($urandom_range(1));
        seed      = LFSR_W'($urandom);
        mode      = 2'($urandom);
        pattern   = SYM_W'($urandom);
      end
      if (sym.valid && rdy) begin
        e = exp_q.pop_front();
        chk("sym_data", 32'(sym.data), 32'(e.d));
        chk("sym_sof",  32'(sym.sof),  32'(e.s));
        chk("sym_eof",  32'(sym.eof),  32'(e.e));
        rx_q.push_back(sym.data);
        if (record_stream) stream_q.push_back(sym.data);
        got++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        hd   = sym.data;
        hs   = sym.sof;
        he   = sym.eof;
      end
      @(negedge clk);
      cyc++;
    end
    chk("frame_symbol_count", 32'(got), 32'(nsym));
    start     = 1'b0;
    seed_load = 1'b0;
    sym.ready = 1'b0;
    if (got == FRAME_LEN) begin
      chk("after_eof_valid", 32'(sym.valid), 32'h0);
      chk("after_eof_busy",  32'(busy),      32'h0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    seed_load = 1'b0;
    seed      = '0;
    mode      = 2'd0;
    pattern   = '0;
    sym.ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    m_st  = 32'(SEED);

    // Seed 7'h7F then PRBS7: first symbols F, E, 0
    seed_load = 1'b1;
    seed      = 15'h007F;
    mode      = 2'd0;
    m_seed(32'h7F, 0);
    @(negedge clk);
    seed_load     = 1'b0;
    record_stream = 1'b1;
    start_frame(0, 0, 1'b0, 0);
    recv(100, 1'b0, FRAME_LEN);
    chk("prbs7_sym0", 32'(rx_q[0]), 32'hF);
    chk("prbs7_sym1", 32'(rx_q[1]), 32'hE);
    chk("prbs7_sym2", 32'(rx_q[2]), 32'h0);

    // 127 more back-to-back PRBS7 frames: symbol stream period is 127
    for (int f = 0; f < 127; f++) begin
      start_frame(0, 0, 1'b0, 0);
      recv(100, 1'b0, FRAME_LEN);
    end
    record_stream = 1'b0;
    chk("stream_len", 32'(stream_q.size()), 32'(128 * FRAME_LEN));
    for (int i = 0; i < 200; i++)
      chk("period_127", 32'(stream_q[i + 127]), 32'(stream_q[i]));

    // Backpressure with RUN-time noise, reseeded to replay the first frame
    start_frame(0, 0, 1'b1, 32'h7F);
    recv(55, 1'b1, FRAME_LEN);
    for (int i = 0; i < FRAME_LEN; i++)
      chk("bp_vs_nostall", 32'(rx_q[i]), 32'(stream_q[i]));
    start_frame(0, 0, 1'b0, 0);
    recv(40, 1'b1, FRAME_LEN);

    // Counter mode, two frames, restarting at 0
    for (int f = 0; f < 2; f++) begin
      start_frame(2, 0, 1'b0, 0);
      recv(70, 1'b1, FRAME_LEN);
      chk("cnt_first", 32'(rx_q[0]), 32'h0);
      chk("cnt_wrap",  32'(rx_q[16]), 32'h0);
    end

    // Fixed pattern, pattern input scrambled during the frame
    start_frame(3, 32'hA, 1'b0, 0);
    recv(80, 1'b1, FRAME_LEN);

    // seed_load + start with zero seed: starts from all-ones
    start_frame(0, 0, 1'b1, 0);
    recv(100, 1'b0, FRAME_LEN);
    chk("zero_seed_sym0", 32'(rx_q[0]), 32'hF);

    // PRBS15 frame then reset mid-frame at symbol 20
    start_frame(1, 0, 1'b0, 0);
    recv(100, 1'b0, 20);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    reset = 1'b0;
    exp_q.delete();
    m_st = 32'(SEED);

    // After reset PRBS15 runs from SEED
    start_frame(1, 0, 1'b0, 0);
    chk("prbs15_sof", 32'(sym.sof), 32'h1);
    recv(75, 1'b0, FRAME_LEN);
    chk("prbs15_sym0", 32'(rx_q[0]), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
